// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for an external combinational ALU: registers the ALU operands,
// waits a fixed settle time, captures the result and counts overflow events.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic [3:0]       req_ctrl,
    input  logic [2:0]       req_bonus,

    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_bonus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             rsp_err,

    output logic [7:0]       ovf_count,
    input  logic             cnt_clr
);

    // Out-of-range SETTLE values are clamped into the 4-bit counter range.
    localparam int unsigned SettleClamped = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [3:0]  SettleInit    = 4'(SettleClamped);

    typedef enum logic [1:0] {
        StIdle,
        StSettleWait,
        StResp,
        StErrResp
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0] alu_src1_q, alu_src1_d;
    logic [WIDTH-1:0] alu_src2_q, alu_src2_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [2:0]       alu_bonus_q, alu_bonus_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       ovf_count_q, ovf_count_d;
    logic             ovf_event;

    function automatic logic ctrl_legal(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        alu_src1_d     = alu_src1_q;
        alu_src2_d     = alu_src2_q;
        alu_ctrl_d     = alu_ctrl_q;
        alu_bonus_d    = alu_bonus_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_cout_d     = rsp_cout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        ovf_event      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (ctrl_legal(req_ctrl)) begin
                        alu_src1_d   = req_src1;
                        alu_src2_d   = req_src2;
                        alu_ctrl_d   = req_ctrl;
                        alu_bonus_d  = req_bonus;
                        settle_cnt_d = SettleInit;
                        state_d      = StSettleWait;
                    end else begin
                        // ALU drive is left untouched so it keeps the last legal operation.
                        rsp_result_d   = '0;
                        rsp_zero_d     = 1'b0;
                        rsp_cout_d     = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_err_d      = 1'b1;
                        state_d        = StErrResp;
                    end
                end
            end
            StSettleWait: begin
                settle_cnt_d = settle_cnt_q - 4'd1;
                if (settle_cnt_q <= 4'd1) begin
                    settle_cnt_d   = 4'd0;
                    rsp_result_d   = alu_result;
                    rsp_zero_d     = alu_zero;
                    rsp_cout_d     = alu_cout;
                    rsp_overflow_d = alu_overflow;
                    rsp_err_d      = 1'b0;
                    ovf_event      = alu_overflow;
                    state_d        = StResp;
                end
            end
            StResp, StErrResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear wins over a same-cycle overflow capture; the count sticks at 255.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (cnt_clr) begin
            ovf_count_d = 8'd0;
        end else if (ovf_event && (ovf_count_q != 8'hFF)) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            settle_cnt_q   <= 4'd0;
            alu_src1_q     <= '0;
            alu_src2_q     <= '0;
            alu_ctrl_q     <= 4'd0;
            alu_bonus_q    <= 3'd0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_cout_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            ovf_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            alu_src1_q     <= alu_src1_d;
            alu_src2_q     <= alu_src2_d;
            alu_ctrl_q     <= alu_ctrl_d;
            alu_bonus_q    <= alu_bonus_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_cout_q     <= rsp_cout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp) || (state_q == StErrResp);
    assign alu_src1     = alu_src1_q;
    assign alu_src2     = alu_src2_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign alu_bonus    = alu_bonus_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table of ALU transactions plus hand-written sequences
// for backpressure, illegal codes, counter saturation/clear, long settle and mid-flight reset.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } alu_out_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_4 = 1'b0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic [3:0]  req_ctrl = '0;
    logic [2:0]  req_bonus = '0;
    logic        rsp_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        req_ready, rsp_valid, rsp_zero, rsp_cout, rsp_overflow, rsp_err;
    logic [31:0] alu_src1, alu_src2, rsp_result;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_bonus;
    logic [7:0]  ovf_count;
    alu_out_t    alu;

    logic        req_ready_4, rsp_valid_4, rsp_zero_4, rsp_cout_4, rsp_overflow_4, rsp_err_4;
    logic [31:0] alu_src1_4, alu_src2_4, rsp_result_4;
    logic [3:0]  alu_ctrl_4;
    logic [2:0]  alu_bonus_4;
    logic [7:0]  ovf_count_4;
    alu_out_t    alu_4;

    int checks = 0;
    int errors = 0;
    vec_t vecs[10];
    vec_t ovf_vec;

    // Reference ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, C NOR, D XOR.
    function automatic alu_out_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        alu_out_t   r;
        logic [32:0] s;
        r = '0;
        case (op)
            4'h0: r.res = a & b;
            4'h1: r.res = a | b;
            4'h2: begin
                s     = {1'b0, a} + {1'b0, b};
                r.res = s[31:0];
                r.c   = s[32];
                r.o   = (a[31] == b[31]) && (r.res[31] != a[31]);
            end
            4'h6: begin
                s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res = s[31:0];
                r.c   = s[32];
                r.o   = (a[31] != b[31]) && (r.res[31] != a[31]);
            end
            4'h7: r.res = {31'd0, ($signed(a) < $signed(b))};
            4'hC: r.res = ~(a | b);
            4'hD: r.res = a ^ b;
            default: r.res = '0;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    assign alu   = alu_model(alu_src1, alu_src2, alu_ctrl);
    assign alu_4 = alu_model(alu_src1_4, alu_src2_4, alu_ctrl_4);

    alu_op_sequencer #(.WIDTH(32), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2), .req_ctrl(req_ctrl), .req_bonus(req_bonus),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
        .alu_result(alu.res), .alu_zero(alu.z), .alu_cout(alu.c), .alu_overflow(alu.o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .ovf_count(ovf_count), .cnt_clr(cnt_clr)
    );

    alu_op_sequencer #(.WIDTH(32), .SETTLE(4)) u_dut_4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_src1(req_src1), .req_src2(req_src2), .req_ctrl(req_ctrl), .req_bonus(req_bonus),
        .alu_src1(alu_src1_4), .alu_src2(alu_src2_4), .alu_ctrl(alu_ctrl_4),
        .alu_bonus(alu_bonus_4),
        .alu_result(alu_4.res), .alu_zero(alu_4.z), .alu_cout(alu_4.c), .alu_overflow(alu_4.o),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_result(rsp_result_4),
        .rsp_zero(rsp_zero_4), .rsp_cout(rsp_cout_4), .rsp_overflow(rsp_overflow_4),
        .rsp_err(rsp_err_4), .ovf_count(ovf_count_4), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_src1  = v.a;
        req_src2  = v.b;
        req_ctrl  = v.ctrl;
        req_bonus = 3'd0;
    endtask

    // Single transaction on the SETTLE=1 instance with rsp_ready held high throughout.
    // Latency counts edges from and including the accept edge.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        int exp_lat;
        exp_lat   = v.e ? 1 : 2;
        rsp_ready = 1'b1;
        drive_req(v);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, rsp_result, v.res);
        check({tag, " z/c/o/err"}, {28'd0, rsp_zero, rsp_cout, rsp_overflow, rsp_err},
              {28'd0, v.z, v.c, v.o, v.e});
        step();
        check({tag, " back to idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'h1, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'hC, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'hD, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{4'h3, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{4'hF, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        ovf_vec = '{4'h6, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state, with req_valid asserted to confirm it is ignored under reset.
        req_valid = 1'b1;
        drive_req(vecs[0]);
        step();
        step();
        req_valid = 1'b0;
        rst_n = 1'b1;
        check("reset req_ready/rsp_valid", {30'd0, req_ready, rsp_valid}, 32'd2);
        check("reset alu_src1", alu_src1, 32'd0);
        check("reset rsp_result/err", {rsp_result[30:0], rsp_err}, 32'd0);
        check("reset ovf_count", {24'd0, ovf_count}, 32'd0);
        check("reset dut4 ready/valid", {30'd0, req_ready_4, rsp_valid_4}, 32'd2);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end
        check("table ovf_count", {24'd0, ovf_count}, 32'd1);

        // Held response under backpressure; new requests are ignored meanwhile.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clear ovf_count", {24'd0, ovf_count}, 32'd0);
        rsp_ready = 1'b0;
        drive_req(ovf_vec);
        req_valid = 1'b1;
        step();
        lat = 1;
        req_src1 = 32'h0BAD0BAD;
        req_ctrl = 4'h0;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("sub latency", lat, 32'd2);
        check("sub ovf_count", {24'd0, ovf_count}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d result", i), rsp_result, 32'h80000000);
            check($sformatf("hold%0d flags", i),
                  {27'd0, rsp_valid, req_ready, rsp_zero, rsp_cout, rsp_overflow}, 32'h11);
            check($sformatf("hold%0d alu_src1", i), alu_src1, 32'h7FFFFFFF);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("release idle", {30'd0, rsp_valid, req_ready}, 32'd1);

        // Illegal code leaves ALU drive untouched; the held SUB keeps alu_overflow high.
        run_txn(vecs[8], "illegal");
        check("illegal alu_src", {alu_src1[15:0], alu_src2[15:0]}, 32'hFFFFFFFF);
        check("illegal alu_ctrl", {28'd0, alu_ctrl}, 32'd6);
        check("illegal ovf_count", {24'd0, ovf_count}, 32'd1);

        // Saturation: 256 further overflow responses from 1.
        for (int i = 0; i < 256; i++) begin
            run_txn(ovf_vec, $sformatf("sat%0d", i));
            if (i == 253) check("count at 255", {24'd0, ovf_count}, 32'd255);
        end
        check("count saturated", {24'd0, ovf_count}, 32'd255);

        // Clear on the capture edge wins over the increment.
        rsp_ready = 1'b0;
        drive_req(ovf_vec);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr edge rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("clr edge ovf_count", {24'd0, ovf_count}, 32'd0);
        rsp_ready = 1'b1;
        step();

        // SETTLE=4 instance: SLT of equal values.
        req_src1  = 32'h11111111;
        req_src2  = 32'h11111111;
        req_ctrl  = 4'h7;
        req_bonus = 3'd0;
        req_valid_4 = 1'b1;
        step();
        req_valid_4 = 1'b0;
        lat = 1;
        while (!rsp_valid_4 && lat < 40) begin
            step();
            lat++;
        end
        check("settle4 latency", lat, 32'd5);
        check("settle4 result", rsp_result_4, 32'd0);
        check("settle4 zero/err", {30'd0, rsp_zero_4, rsp_err_4}, 32'd2);
        step();
        check("settle4 idle", {30'd0, rsp_valid_4, req_ready_4}, 32'd1);

        // Reset while in SETTLE_WAIT drops the transaction.
        run_txn(ovf_vec, "pre-reset");
        rsp_ready = 1'b0;
        drive_req(vecs[6]);
        req_valid = 1'b1;
        step();
        check("mid txn busy", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        cnt_clr = 1'b1;
        step();
        check("rst ready/valid", {30'd0, req_ready, rsp_valid}, 32'd2);
        check("rst alu_src", alu_src1 | alu_src2, 32'd0);
        check("rst alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst rsp", {rsp_result[27:0], rsp_zero, rsp_cout, rsp_overflow, rsp_err}, 32'd0);
        check("rst ovf_count", {24'd0, ovf_count}, 32'd0);
        step();
        check("rst ignores req_valid", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        req_valid = 1'b0;
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post-rst quiet%0d", i), {30'd0, rsp_valid, req_ready}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, cycles allowed for the combinational ALU to settle before capture.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have ports req_src1, req_src2  input  WIDTH  operands.
REQ-008 SHALL have ports req_ctrl  input  4  ALU_control code; req_bonus  input  3  bonus_control code.
REQ-009 SHALL have ports alu_src1, alu_src2  output  WIDTH; alu_ctrl  output  4; alu_bonus  output  3  registered drive to the ALU.
REQ-010 SHALL have ports alu_result  input  WIDTH; alu_zero, alu_cout, alu_overflow  input  1  ALU outputs.
REQ-011 SHALL have ports rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 SHALL have ports rsp_result  output  WIDTH; rsp_zero, rsp_cout, rsp_overflow, rsp_err  output  1  registered response.
REQ-013 SHALL have ports ovf_count  output  8  overflow event counter; cnt_clr  input  1  counter clear.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE_WAIT, RESP, ERR_RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-016 SHALL treat req_ctrl in {0,1,2,6,7,C,D} as legal; all other codes illegal.
REQ-017 SHALL, on accepting a legal request, load alu_* registers from req_* on that edge, load settle counter with SETTLE, and go to SETTLE_WAIT.
REQ-018 SHALL in SETTLE_WAIT decrement the counter each edge and, on the edge where it reaches 0, capture alu_result/zero/cout/overflow into rsp_*, clear rsp_err, go to RESP; rsp_valid is thus high SETTLE+1 edges after acceptance.
REQ-019 SHALL, on accepting an illegal request, leave alu_* unchanged, set rsp_result=0, rsp_zero=rsp_cout=rsp_overflow=0, rsp_err=1, go to ERR_RESP (rsp_valid high 1 edge after acceptance).
REQ-020 SHALL assert rsp_valid in RESP and ERR_RESP only, holding all rsp_* stable until an edge with rsp_ready=1, then return to IDLE.
REQ-021 SHALL accept rsp_ready before rsp_valid without effect; an asserted rsp_ready in IDLE/SETTLE_WAIT is ignored.
REQ-022 SHALL keep alu_* registers stable from acceptance until the next acceptance so the ALU inputs never glitch during a transaction.
REQ-023 SHALL increment ovf_count on each capture edge with alu_overflow=1, saturating at 255 (no wrap).
REQ-024 SHALL give cnt_clr priority over a simultaneous increment (count becomes 0).
REQ-025 SHALL not affect ovf_count on error responses.
REQ-026 SHALL perform no operation on req_valid while not in IDLE; requester holds the request.

Reset
REQ-027 SHALL, on an edge with rst_n=0, go to IDLE and set req_ready=1 after reset, rsp_valid=0, rsp_* =0, rsp_err=0, alu_* =0, ovf_count=0, settle counter=0, regardless of state.
REQ-028 SHALL drop any in-flight transaction on reset mid-operation; no response is produced for it.
REQ-029 SHALL ignore req_valid and cnt_clr on edges where rst_n=0.

Verification
REQ-030 SHALL cover: ADD ctrl=2, src1=FFFFFFFF, src2=00000001, SETTLE=1, rsp_ready=1 -> rsp_valid 2 edges after accept, result=00000000, zero=1, cout=1, overflow=0, err=0.
REQ-031 SHALL cover: SUB ctrl=6, 7FFFFFFF - FFFFFFFF, rsp_ready low 5 cycles -> rsp held stable, overflow=1, ovf_count 0->1, req_ready=0 until rsp_ready edge.
REQ-032 SHALL cover: illegal ctrl=3 -> rsp_valid 1 edge after accept, err=1, result=0, alu_* unchanged from previous transaction.
REQ-033 SHALL cover: 256 consecutive overflow responses -> ovf_count saturates at 255; cnt_clr asserted on an overflow capture edge -> 0.
REQ-034 SHALL cover: rst_n low during SETTLE_WAIT -> next cycle IDLE, req_ready=1, rsp_valid never asserted, all outputs 0.
REQ-035 SHALL cover: SETTLE=4, SLT ctrl=7 bonus=0, 11111111 vs 11111111 -> rsp_valid exactly 5 edges after accept, result=00000000, zero=1.
